alu_md: RTL and testbench

Parametrised successor to the single-cycle ALU. It keeps all twelve base operations as single-cycle combinational ops, with carry and overflow flags corrected for subtraction. It adds an iterative multiply/divide unit covering the eight RV32M operations, controlled by a Start/Busy/Done handshake. It sits in the execute stage. The hazard unit stalls the pipeline while Busy is high.

---
 rtl/alu_md.sv | 182 ++++++++++++++++++
 tb/tb_alu_md.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle base ops plus an iterative RV32M multiply/divide
// unit driven by a Start/Busy/Done handshake.
module alu_md #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int SHIFT_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Start,
    input  logic [DATA_WIDTH-1:0]     SrcA,
    input  logic [DATA_WIDTH-1:0]     SrcB,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]     PC,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic                      Zero,
    output logic                      N,
    output logic                      C,
    output logic                      V,
    output logic                      Busy,
    output logic                      Done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a, r_b, r_opnd, r_res;
    logic [2*W-1:0]  r_acc;
    logic            r_neg_a, r_neg_b;

    logic [W:0]      w_sum;
    logic [W-1:0]    w_b_eff, w_base_res;
    logic            w_sub, w_base_c, w_base_v;
    logic [SHIFT_WIDTH-1:0] w_shamt;

    assign w_shamt = SrcB[SHIFT_WIDTH-1:0];
    assign w_sub   = (ALUControl[3:0] == 4'd1);
    assign w_b_eff = w_sub ? ~SrcB : SrcB;
    assign w_sum   = {1'b0, SrcA} + {1'b0, w_b_eff} + {{W{1'b0}}, w_sub};

    always_comb begin
        w_base_res = w_sum[W-1:0];
        w_base_c   = 1'b0;
        w_base_v   = 1'b0;
        case (ALUControl[3:0])
            4'd2:  w_base_res = SrcA << w_shamt;
            4'd3:  w_base_res = {{(W-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            4'd4:  w_base_res = {{(W-1){1'b0}}, SrcA < SrcB};
            4'd5:  w_base_res = SrcA ^ SrcB;
            4'd6:  w_base_res = SrcA >> w_shamt;
            4'd7:  w_base_res = $unsigned($signed(SrcA) >>> w_shamt);
            4'd8:  w_base_res = SrcA | SrcB;
            4'd9:  w_base_res = SrcA & SrcB;
            4'd10: w_base_res = (SrcB << 12) + PC;
            4'd11: w_base_res = SrcB << 12;
            default: begin
                // add, sub and the 12..15 aliases: sub uses the inverted operand sign
                w_base_c = w_sum[W];
                w_base_v = (SrcA[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != SrcA[W-1]);
            end
        endcase
    end

    // Mul/div operand preparation at launch
    logic [2:0]   w_md_op;
    logic         w_is_div, w_sa, w_sb, w_start;
    logic [W-1:0] w_a_mag, w_b_mag;

    assign w_md_op  = ALUControl[3] ? 3'd0 : ALUControl[2:0];
    assign w_is_div = w_md_op[2];
    assign w_sa     = SrcA[W-1] && (w_md_op == 3'd1 || w_md_op == 3'd2 ||
                                    w_md_op == 3'd4 || w_md_op == 3'd6);
    assign w_sb     = SrcB[W-1] && (w_md_op == 3'd1 || w_md_op == 3'd4 || w_md_op == 3'd6);
    assign w_a_mag  = w_sa ? -SrcA : SrcA;
    assign w_b_mag  = w_sb ? -SrcB : SrcB;
    assign w_start  = Start && ALUControl[4] && (r_state == S_IDLE || r_state == S_DONE);

    // One iteration: shift-add for multiply, restoring step for divide
    logic [W:0]     w_madd, w_trial;
    logic [2*W-1:0] w_acc_next;

    assign w_madd  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_trial = {r_acc[2*W-1:W], r_acc[W-1]} - {1'b0, r_opnd};

    always_comb begin
        if (!r_op[2])
            w_acc_next = {w_madd, r_acc[W-1:1]};
        else if (!w_trial[W])
            w_acc_next = {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
        else
            w_acc_next = {r_acc[2*W-2:0], 1'b0};
    end

    // Sign fix-up and special cases
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo, w_rem, w_fin;
    logic           w_ovf, w_dz;

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    assign w_dz   = (r_b == '0);
    assign w_ovf  = !r_op[0] && (r_a == {1'b1, {(W-1){1'b0}}}) && (r_b == '1);

    always_comb begin
        w_fin = w_prod[2*W-1:W];
        case (r_op)
            3'd0:       w_fin = w_prod[W-1:0];
            3'd4, 3'd5: w_fin = w_dz ? '1 : (w_ovf ? r_a : w_quo);
            3'd6, 3'd7: w_fin = w_dz ? r_a : (w_ovf ? '0 : w_rem);
            default:    w_fin = w_prod[2*W-1:W];
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(W - 1)) w_next = S_FIN;
            S_FIN:   w_next = S_DONE;
            S_DONE:  w_next = w_start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_op    <= w_md_op;
                r_a     <= SrcA;
                r_b     <= SrcB;
                r_neg_a <= w_sa;
                r_neg_b <= w_sb;
                r_cnt   <= '0;
                r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                r_acc   <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIN) begin
                r_res <= w_fin;
            end
        end
    end

    always_comb begin
        if (r_state == S_DONE) begin
            ALUResult = r_res;
            C         = 1'b0;
            V         = 1'b0;
        end else if (ALUControl[4]) begin
            ALUResult = '0;
            C         = 1'b0;
            V         = 1'b0;
        end else begin
            ALUResult = w_base_res;
            C         = w_base_c;
            V         = w_base_v;
        end
    end

    assign Zero = (ALUResult == '0);
    assign N    = ALUResult[W-1];
    assign Busy = (r_state == S_RUN) || (r_state == S_FIN);
    assign Done = (r_state == S_DONE);
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: base ops, mul/div results, latency, back-to-back and abort.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        rst, Start;
    logic [31:0] SrcA, SrcB, PC;
    logic [4:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero, N, C, V, Busy, Done;

    int n_chk  = 0;
    int n_fail = 0;

    alu_md #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(5), .SHIFT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .Start(Start), .SrcA(SrcA), .SrcB(SrcB),
        .ALUControl(ALUControl), .PC(PC), .ALUResult(ALUResult), .Zero(Zero),
        .N(N), .C(C), .V(V), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Base op applied in IDLE; checked after combinational settle.
    task automatic base(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input logic ez, input logic en, input logic ec, input logic ev);
        @(negedge clk);
        ALUControl = op; SrcA = a; SrcB = b;
        #1;
        chk(tag, ALUResult, exp);
        chk({tag, "_flags"}, {28'd0, Zero, N, C, V}, {28'd0, ez, en, ec, ev});
    endtask

    // Called in the negedge phase; Start is sampled at the following posedge.
    task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControl = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0; SrcA = ~a; SrcB = ~b; ALUControl = 5'b00001;
    endtask

    task automatic wait_done(input int pulse_at, output int cycles, output int busy_n,
                             output logic [31:0] res, output logic [3:0] flags,
                             output logic got);
        cycles = 0; busy_n = 0; got = 1'b0; res = '0; flags = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (i == pulse_at) begin
                Start = 1'b1; ALUControl = 5'b10101; SrcA = 32'd100; SrcB = 32'd3;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                got = 1'b1; res = ALUResult; flags = {Zero, N, C, V};
            end else if (Busy) begin
                busy_n++;
            end
        end
        Start = 1'b0;
    endtask

    task automatic md(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        int cyc, bn;
        logic [31:0] res;
        logic [3:0] fl;
        logic got;
        launch(op, a, b);
        wait_done(-1, cyc, bn, res, fl, got);
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk(tag, res, exp);
        chk({tag, "_flags"}, {28'd0, fl}, {28'd0, exp == 32'd0, exp[31], 2'b00});
        chk({tag, "_lat"}, cyc, 32'd34);
    endtask

    initial begin
        int cyc, bn, dn;
        logic [31:0] res;
        logic [3:0] fl;
        logic got;

        rst = 1'b1; Start = 1'b0; SrcA = '0; SrcB = '0; PC = '0; ALUControl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_res", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);

        base("add_wrap",  5'b00000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1, 0, 1, 0);
        base("add_ovf",   5'b00000, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 0, 1, 0, 1);
        base("sub_ovf",   5'b00001, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 0, 0, 1, 1);
        base("sub_zero",  5'b00001, 32'd5,         32'd5,        32'h0000_0000, 1, 0, 1, 0);
        base("sub_borrow",5'b00001, 32'd3,         32'd5,        32'hFFFF_FFFE, 0, 1, 0, 0);
        base("sll",       5'b00010, 32'd1,         32'd31,       32'h8000_0000, 0, 1, 0, 0);
        base("sll_mask",  5'b00010, 32'd1,         32'd33,       32'h0000_0002, 0, 0, 0, 0);
        base("slt",       5'b00011, 32'hFFFF_FFFF, 32'd1,        32'd1,         0, 0, 0, 0);
        base("sltu",      5'b00100, 32'hFFFF_FFFF, 32'd1,        32'd0,         1, 0, 0, 0);
        base("xor",       5'b00101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0, 1, 0, 0);
        base("srl",       5'b00110, 32'h8000_0000, 32'd4,        32'h0800_0000, 0, 0, 0, 0);
        base("sra",       5'b00111, 32'h8000_0000, 32'd4,        32'hF800_0000, 0, 1, 0, 0);
        base("or",        5'b01000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 0, 0, 0);
        base("and",       5'b01001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 1, 0, 0, 0);
        PC = 32'h100;
        base("auipc",     5'b01010, 32'd0,         32'd1,        32'h0000_1100, 0, 0, 0, 0);
        base("lui",       5'b01011, 32'd0,         32'h000A_BCDE, 32'hABCD_E000, 0, 1, 0, 0);
        base("alias_add", 5'b01110, 32'd2,         32'd3,        32'd5,         0, 0, 0, 0);
        base("md_idle",   5'b10000, 32'd5,         32'd5,        32'd0,         1, 0, 0, 0);

        @(negedge clk);
        launch(5'b10001, 32'h8000_0000, 32'h8000_0000);
        wait_done(-1, cyc, bn, res, fl, got);
        chk("mulh_done", {31'd0, got}, 32'd1);
        chk("mulh", res, 32'h4000_0000);
        chk("mulh_busy_cycles", bn, 32'd33);
        chk("mulh_done_cycle", cyc, 32'd34);
        @(negedge clk);
        chk("done_pulse_width", {31'd0, Done}, 32'd0);
        chk("idle_busy", {31'd0, Busy}, 32'd0);

        md("mulhsu",   5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md("mul_neg",  5'b10000, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9);
        md("mul_alias",5'b11000, 32'd6,         32'd7,         32'd42);
        md("div_neg",  5'b10100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        md("rem_neg",  5'b10110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        md("divu",     5'b10101, 32'd100,       32'd7,         32'd14);
        md("remu",     5'b10111, 32'd100,       32'd7,         32'd2);
        md("divu_dz",  5'b10101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF);
        md("div_dz",   5'b10100, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);
        md("rem_dz",   5'b10110, 32'd5,         32'd0,         32'd5);
        md("div_ovf",  5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md("rem_ovf",  5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Back-to-back: MUL 3x4 launched in the DONE cycle of a DIVU
        launch(5'b10101, 32'd50, 32'd5);
        wait_done(-1, cyc, bn, res, fl, got);
        chk("b2b_first", res, 32'd10);
        launch(5'b10000, 32'd3, 32'd4);
        wait_done(-1, cyc, bn, res, fl, got);
        chk("b2b_done", {31'd0, got}, 32'd1);
        chk("b2b_mul", res, 32'd12);
        chk("b2b_cycles", cyc, 32'd34);

        // Start pulsed during RUN is ignored
        launch(5'b10011, 32'd1000, 32'd1000);
        wait_done(5, cyc, bn, res, fl, got);
        chk("run_start_res", res, 32'd0);
        chk("run_start_cycles", cyc, 32'd34);

        // Abort in RUN
        launch(5'b10000, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) dn++;
        end
        chk("abort_no_done", dn, 32'd0);
        md("mulhu_after_abort", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
